// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the datapath around it.
package pipe_pkg;

  // Controller operating modes
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Register-file index width and program-counter width of the datapath
  localparam int unsigned REG_W = 5;
  localparam int unsigned PC_W  = 12;

  // addi x0, x0, 0 -- what fetch/decode is loaded with on a flush
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bus between the stage registers (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_pkg::*;

  // Fields published by the stage registers
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             mem_br_taken;
  logic             dmem_req;
  logic             dmem_ready;

  // Enables, bubbles and status driven back by the controller
  logic             pcwrite;
  logic             fdwrite;
  logic             fd_flush;
  logic             de_flush;
  logic             em_flush;
  logic             pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           mem_br_taken, dmem_req, dmem_ready,
    input  pcwrite, fdwrite, fd_flush, de_flush, em_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           mem_br_taken, dmem_req, dmem_ready,
    output pcwrite, fdwrite, fd_flush, de_flush, em_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: advance on an event unless already saturated
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + 1'b1;
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stalls, MEM-stage branch flushes and dmem waits
// with a timeout watchdog, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  // Wait counter must hold MAX_WAIT; never narrower than 4 bits
  localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic load_use;
  logic mem_stall;
  logic run_eval;
  logic br_flush;
  logic stall_evt;

  logic pcwrite_c, fdwrite_c, fd_flush_c, de_flush_c, em_flush_c, pipe_hold_c;

  // A load in EX whose destination is read by the instruction in decode.
  // x0 is hardwired, so a load into it never creates a dependency.
  assign load_use = bus.ex_memread && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  // Next state and stage-register controls; combinational so the stage
  // registers see them at the same edge that updates the controller state
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    run_eval    = 1'b0;
    br_flush    = 1'b0;
    pcwrite_c   = 1'b1;
    fdwrite_c   = 1'b1;
    fd_flush_c  = 1'b0;
    de_flush_c  = 1'b0;
    em_flush_c  = 1'b0;
    pipe_hold_c = 1'b0;

    if (rst) begin
      pcwrite_c  = 1'b0;
      fdwrite_c  = 1'b0;
      fd_flush_c = 1'b1;
      de_flush_c = 1'b1;
      em_flush_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          run_eval = 1'b1;
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            // Access completes: this cycle behaves like a normal RUN cycle
            run_eval = 1'b1;
            state_d  = RUN;
          end else begin
            // Whole pipe frozen; a taken branch in ex/mem waits for release
            pcwrite_c   = 1'b0;
            fdwrite_c   = 1'b0;
            pipe_hold_c = 1'b1;
            if (wait_q == WAIT_LIMIT) begin
              state_d = HALT;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end
        end
        HALT: begin
          pcwrite_c   = 1'b0;
          fdwrite_c   = 1'b0;
          pipe_hold_c = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase

      if (run_eval) begin
        if (mem_stall) begin
          pcwrite_c   = 1'b0;
          fdwrite_c   = 1'b0;
          pipe_hold_c = 1'b1;
          state_d     = MEM_WAIT;
          wait_d      = WAIT_W'(1);
        end else if (bus.mem_br_taken) begin
          // Squashes everything younger, including a load-use victim
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
          em_flush_c = 1'b1;
          br_flush   = 1'b1;
        end else if (load_use) begin
          // One bubble; next cycle the load has moved on to MEM
          pcwrite_c  = 1'b0;
          fdwrite_c  = 1'b0;
          de_flush_c = 1'b1;
        end
      end
    end
  end

  // Controller state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Stalls are counted only while the pipeline is live (not in reset or HALT)
  assign stall_evt = !rst && (state_q != HALT) && !pcwrite_c;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_evt),
    .value (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_flush),
    .value (bus.flush_cnt)
  );

  assign bus.pcwrite     = pcwrite_c;
  assign bus.fdwrite     = fdwrite_c;
  assign bus.fd_flush    = fd_flush_c;
  assign bus.de_flush    = de_flush_c;
  assign bus.em_flush    = em_flush_c;
  assign bus.pipe_hold   = pipe_hold_c;
  assign bus.mem_timeout = (state_q == HALT);

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control-side counterpart of the stage registers (PC, fetch/decode, decode/ex, ex/mem, mem/wb). It consumes the fields those registers publish and drives their write-enable and bubble/flush inputs.
- Handles three hazard classes:
  - load-use stalls,
  - taken-branch flushes resolved in the MEM stage,
  - multi-cycle data-memory waits, with a timeout watchdog.
- Keeps stall and flush performance counters.

Parameters:
- MAX_WAIT, 15, maximum consecutive dmem wait cycles before a timeout is declared.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 field of instruction held in fetch/decode register.
- id_rs2  in  5  rs2 field of instruction held in fetch/decode register.
- id_use_rs1  in  1  decoded instruction reads rs1.
- id_use_rs2  in  1  decoded instruction reads rs2.
- ex_rd  in  5  rd held in decode/ex register.
- ex_memread  in  1  memread held in decode/ex register.
- mem_br_taken  in  1  branch in ex/mem resolved taken (from branch, zero, neg).
- dmem_req  in  1  ex/mem instruction is a memory access (memread | memwrite).
- dmem_ready  in  1  data memory completes access this cycle.
- pcwrite  out  1  PC register enable.
- fdwrite  out  1  fetch/decode register enable.
- fd_flush  out  1  load NOP into fetch/decode.
- de_flush  out  1  zero control fields entering decode/ex (bubble).
- em_flush  out  1  zero control fields entering ex/mem.
- pipe_hold  out  1  freeze decode/ex, ex/mem, mem/wb.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  cycles with pcwrite=0 outside reset/timeout.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- State register: RUN, MEM_WAIT, HALT. Counters `wait_cnt` (4 bits minimum, sized for MAX_WAIT), `stall_cnt`, `flush_cnt`.
- Control outputs are combinational from state and current inputs, so that the stage registers sample them at the same edge. State and counters are registered.
- Reset (rst=1 at edge, and throughout while rst held):
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - While rst=1: pcwrite=0, fdwrite=0, fd_flush=1, de_flush=1, em_flush=1, pipe_hold=0.
  - A reset mid-wait or mid-stall simply abandons that state.
- Hazard definitions:
  - load_use = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - mem_stall = dmem_req & !dmem_ready.
- RUN priority, highest first:
  1. mem_stall: pcwrite=0, fdwrite=0, pipe_hold=1, all flushes 0. Next state MEM_WAIT, wait_cnt=1.
  2. mem_br_taken: pcwrite=1 (datapath selects target), fdwrite=1, fd_flush=1, de_flush=1, em_flush=1. flush_cnt+1. This overrides load_use, since the stalled instruction is squashed.
  3. load_use: pcwrite=0, fdwrite=0, de_flush=1. Exactly one bubble; the next cycle the load is in MEM and load_use drops.
  4. Otherwise pcwrite=1, fdwrite=1, all others 0.
- MEM_WAIT:
  - Outputs as RUN case 1 while !dmem_ready.
  - When dmem_ready=1: outputs are evaluated exactly as RUN (branch/load_use rules apply that cycle), and next state is RUN.
  - Otherwise wait_cnt+1. When wait_cnt==MAX_WAIT and still !dmem_ready, next state is HALT.
  - mem_br_taken is ignored while holding; ex/mem is frozen, so it is re-evaluated after release.
- HALT:
  - mem_timeout=1, pcwrite=0, fdwrite=0, pipe_hold=1.
  - Counters frozen. Exit only via rst.
- stall_cnt increments on any cycle in RUN/MEM_WAIT with pcwrite=0; saturates at all-ones. flush_cnt also saturates.
- rd==0 never causes a load_use stall.

Decomposition:
- Shared package `pipe_pkg`: state enum (RUN, MEM_WAIT, HALT), REG_W=5, PC_W=12, NOP instruction constant 32'h00000013.
- Sub-module `sat_counter` (CNT_W, inc, rst, value), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle pcwrite=0, fdwrite=0, de_flush=1; stall_cnt 0→1. Next cycle with ex_memread=0 → pcwrite=1.
- rd=x0: ex_memread=1, ex_rd=0, id_rs2=0, id_use_rs2=1 → no stall, pcwrite=1.
- Branch flush concurrent with load_use: mem_br_taken=1 and load_use true → pcwrite=1, fd/de/em_flush=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles then high → pipe_hold=1 for 3 cycles, stall_cnt=3, state returns to RUN on the ready cycle.
- Timeout: dmem_req=1, dmem_ready=0 for MAX_WAIT+1 cycles → mem_timeout=1, HALT persists until rst=1, then all counters read 0.
- Reset mid-wait: rst asserted during MEM_WAIT → next cycle state RUN, pipe_hold=0, all flushes asserted while rst high.
